l2_request_sequencer: RTL and testbench

- Shares the L2 request path among NUM_PORTS requesters using round-robin arbitration.
- Drives the reservation-tracking block for each accepted request: one strobe with addr, id, lr, sc and store.
- Samples that block's abort and suppresses failed store-conditionals before they reach memory.
- Forwards surviving requests to the L2 memory interface and returns per-port SC completion status.

---
 rtl/l2_request_sequencer.sv | 176 +++++++++++++++++
 tb/tb_l2_request_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_request_sequencer.sv
// Round-robin sequencer for the shared L2 request path: arbitrates requesters, consults the
// reservation tracker once per request, drops aborted store-conditionals, and reports SC outcomes.
module l2_request_sequencer #(
    parameter int NUM_PORTS = 2,
    parameter int IDW       = $clog2(NUM_PORTS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_PORTS-1:0]    req_valid,
    input  logic [NUM_PORTS*30-1:0] req_addr,
    input  logic [NUM_PORTS-1:0]    req_lr,
    input  logic [NUM_PORTS-1:0]    req_sc,
    input  logic [NUM_PORTS-1:0]    req_store,
    output logic [NUM_PORTS-1:0]    req_ack,
    output logic                    rsv_strobe,
    output logic [29:0]             rsv_addr,
    output logic [IDW-1:0]          rsv_id,
    output logic                    rsv_lr,
    output logic                    rsv_sc,
    output logic                    rsv_store,
    input  logic                    rsv_abort,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic [29:0]             mem_addr,
    output logic [IDW-1:0]          mem_id,
    output logic                    mem_lr,
    output logic                    mem_sc,
    output logic                    mem_store,
    output logic                    sc_done,
    output logic [IDW-1:0]          sc_done_id,
    output logic                    sc_fail
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        MEM   = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [IDW-1:0] rr_ptr_reg;
    logic [29:0]    addr_reg;
    logic [IDW-1:0] id_reg;
    logic           lr_reg, sc_reg, store_reg;
    logic           sc_done_reg, sc_fail_reg;
    logic [IDW-1:0] sc_done_id_reg;

    logic [IDW-1:0]       cand_idx [NUM_PORTS];
    logic [NUM_PORTS-1:0] cand_valid;
    logic                 grant_found;
    logic [IDW-1:0]       grant_idx;
    logic [IDW-1:0]       rr_ptr_next;

    // Candidate gi is the port gi places after the round-robin pointer, wrapped modulo NUM_PORTS.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_cand
            logic [IDW:0] sum;
            assign sum            = {1'b0, rr_ptr_reg} + (IDW+1)'(gi);
            assign cand_idx[gi]   = (sum >= (IDW+1)'(NUM_PORTS)) ?
                                    IDW'(sum - (IDW+1)'(NUM_PORTS)) : sum[IDW-1:0];
            assign cand_valid[gi] = req_valid[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (cand_valid[k]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
    end

    assign rr_ptr_next = (grant_idx == IDW'(NUM_PORTS - 1)) ? '0 : grant_idx + IDW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_found) state_next = ISSUE;
            ISSUE:   state_next = (sc_reg && rsv_abort) ? IDLE : MEM;
            MEM:     if (mem_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ack    = '0;
        rsv_strobe = 1'b0;
        rsv_addr   = '0;
        rsv_id     = '0;
        rsv_lr     = 1'b0;
        rsv_sc     = 1'b0;
        rsv_store  = 1'b0;
        mem_valid  = 1'b0;
        mem_addr   = '0;
        mem_id     = '0;
        mem_lr     = 1'b0;
        mem_sc     = 1'b0;
        mem_store  = 1'b0;
        case (state_reg)
            IDLE: begin
                // No ack while in reset: the requester would drop a request we are about to discard.
                if (grant_found && !rst) req_ack[grant_idx] = 1'b1;
            end
            ISSUE: begin
                rsv_strobe = 1'b1;
                rsv_addr   = addr_reg;
                rsv_id     = id_reg;
                rsv_lr     = lr_reg;
                rsv_sc     = sc_reg;
                rsv_store  = store_reg;
            end
            MEM: begin
                mem_valid = 1'b1;
                mem_addr  = addr_reg;
                mem_id    = id_reg;
                mem_lr    = lr_reg;
                mem_sc    = sc_reg;
                mem_store = store_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg     <= '0;
            addr_reg       <= '0;
            id_reg         <= '0;
            lr_reg         <= 1'b0;
            sc_reg         <= 1'b0;
            store_reg      <= 1'b0;
            sc_done_reg    <= 1'b0;
            sc_fail_reg    <= 1'b0;
            sc_done_id_reg <= '0;
        end else begin
            if (state_reg == IDLE && grant_found) begin
                rr_ptr_reg <= rr_ptr_next;
                addr_reg   <= req_addr[30*grant_idx +: 30];
                id_reg     <= grant_idx;
                // LR+SC together is treated as a plain SC.
                lr_reg     <= req_lr[grant_idx] & ~req_sc[grant_idx];
                sc_reg     <= req_sc[grant_idx];
                store_reg  <= req_store[grant_idx];
            end
            sc_done_reg    <= 1'b0;
            sc_fail_reg    <= 1'b0;
            sc_done_id_reg <= '0;
            if (state_reg == ISSUE && sc_reg && rsv_abort) begin
                sc_done_reg    <= 1'b1;
                sc_fail_reg    <= 1'b1;
                sc_done_id_reg <= id_reg;
            end else if (state_reg == MEM && mem_ready && sc_reg) begin
                sc_done_reg    <= 1'b1;
                sc_fail_reg    <= 1'b0;
                sc_done_id_reg <= id_reg;
            end
        end
    end

    assign sc_done    = sc_done_reg;
    assign sc_fail    = sc_fail_reg;
    assign sc_done_id = sc_done_id_reg;

endmodule

// File: tb/tb_l2_request_sequencer.sv
// Randomized scoreboard bench for l2_request_sequencer: a transaction-level timeline model
// predicts acks, strobes, memory requests and SC results; a negedge monitor checks them.
module tb_l2_request_sequencer;

    localparam int N   = 2;
    localparam int IDW = $clog2(N);

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*30-1:0]   req_addr;
    logic [N-1:0]      req_lr, req_sc, req_store;
    logic [N-1:0]      req_ack;
    logic              rsv_strobe, rsv_lr, rsv_sc, rsv_store, rsv_abort;
    logic [29:0]       rsv_addr, mem_addr;
    logic [IDW-1:0]    rsv_id, mem_id, sc_done_id;
    logic              mem_valid, mem_ready, mem_lr, mem_sc, mem_store;
    logic              sc_done, sc_fail;

    always #5 clk = ~clk;

    l2_request_sequencer #(.NUM_PORTS(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_lr(req_lr), .req_sc(req_sc),
        .req_store(req_store), .req_ack(req_ack),
        .rsv_strobe(rsv_strobe), .rsv_addr(rsv_addr), .rsv_id(rsv_id), .rsv_lr(rsv_lr),
        .rsv_sc(rsv_sc), .rsv_store(rsv_store), .rsv_abort(rsv_abort),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_id(mem_id),
        .mem_lr(mem_lr), .mem_sc(mem_sc), .mem_store(mem_store),
        .sc_done(sc_done), .sc_done_id(sc_done_id), .sc_fail(sc_fail)
    );

    typedef struct { int cyc; int id; } ack_t;
    typedef struct { int cyc; logic [29:0] addr; int id; bit lr; bit sc; bit store; } rsv_t;
    typedef struct { int start; int fin; logic [29:0] addr; int id; bit lr; bit sc; bit store; } mem_t;
    typedef struct { int cyc; int id; bit fail; } scd_t;

    ack_t ack_q[$];
    rsv_t rsv_q[$];
    mem_t mem_q[$];
    scd_t sc_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;
    bit mem_prev = 1'b0;
    int zero_chk_cyc = -1;

    task automatic check(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents an output, flags stale ones.
    initial begin
        ack_t a;
        rsv_t r;
        mem_t m;
        scd_t s;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
                    check("ack_missing", cyc, ack_q[0].cyc);
                    void'(ack_q.pop_front());
                end
                while (rsv_q.size() > 0 && rsv_q[0].cyc < cyc) begin
                    check("strobe_missing", cyc, rsv_q[0].cyc);
                    void'(rsv_q.pop_front());
                end
                while (mem_q.size() > 0 && mem_q[0].fin < cyc) begin
                    check("mem_handshake_missing", cyc, mem_q[0].fin);
                    void'(mem_q.pop_front());
                end
                while (sc_q.size() > 0 && sc_q[0].cyc < cyc) begin
                    check("sc_done_missing", cyc, sc_q[0].cyc);
                    void'(sc_q.pop_front());
                end

                if (req_ack != '0) begin
                    if (ack_q.size() == 0) check("ack_unexpected", req_ack, 0);
                    else begin
                        a = ack_q.pop_front();
                        check("ack_cycle", cyc, a.cyc);
                        check("ack_port", req_ack, longint'(1) << a.id);
                    end
                end

                if (rsv_strobe) begin
                    if (rsv_q.size() == 0) check("strobe_unexpected", rsv_strobe, 0);
                    else begin
                        r = rsv_q.pop_front();
                        check("strobe_cycle", cyc, r.cyc);
                        check("rsv_addr", rsv_addr, r.addr);
                        check("rsv_id", rsv_id, r.id);
                        check("rsv_lr_sc_store", {rsv_lr, rsv_sc, rsv_store}, {r.lr, r.sc, r.store});
                    end
                end else begin
                    check("rsv_idle_zero", {rsv_addr, rsv_id, rsv_lr, rsv_sc, rsv_store}, 0);
                end

                if (mem_valid) begin
                    if (mem_q.size() == 0) check("mem_unexpected", mem_valid, 0);
                    else begin
                        m = mem_q[0];
                        if (!mem_prev) check("mem_start_cycle", cyc, m.start);
                        check("mem_addr", mem_addr, m.addr);
                        check("mem_id_lr_sc_store", {mem_id, mem_lr, mem_sc, mem_store},
                              {m.id[IDW-1:0], m.lr, m.sc, m.store});
                        if (mem_ready) begin
                            check("mem_handshake_cycle", cyc, m.fin);
                            void'(mem_q.pop_front());
                        end
                    end
                end else begin
                    check("mem_idle_zero", {mem_addr, mem_id, mem_lr, mem_sc, mem_store}, 0);
                end
                mem_prev = mem_valid;

                if (sc_done) begin
                    if (sc_q.size() == 0) check("sc_done_unexpected", sc_done, 0);
                    else begin
                        s = sc_q.pop_front();
                        check("sc_done_cycle", cyc, s.cyc);
                        check("sc_done_id", sc_done_id, s.id);
                        check("sc_fail", sc_fail, s.fail);
                    end
                end

                if (cyc == zero_chk_cyc) begin
                    check("rst_mid_ctrl_zero", {req_ack, rsv_strobe, mem_valid, sc_done, sc_fail}, 0);
                    check("rst_mid_mem_zero", {mem_addr, mem_id, mem_lr, mem_sc, mem_store}, 0);
                end
            end
        end
    end

    // Stimulus and reference timeline model.
    initial begin
        logic [N-1:0]  pend;
        logic [29:0]   p_addr [N];
        bit            p_lr [N], p_sc [N], p_store [N];
        int            rr, free_cycle, ready_cycle, rst_cyc, phase, g, q, wt;
        bit            abort_plan, lr_e, done_flag;

        pend = '0;
        rr = 0; free_cycle = 0; ready_cycle = 0; rst_cyc = -100; phase = 0;
        abort_plan = 1'b0; done_flag = 1'b0;
        for (int p = 0; p < N; p++) begin
            p_addr[p] = '0; p_lr[p] = 0; p_sc[p] = 0; p_store[p] = 0;
        end

        rst = 1'b1; req_valid = '1; req_addr = '0; req_lr = '0; req_sc = '0; req_store = '0;
        mem_ready = 1'b0; rsv_abort = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl_zero", {req_ack, rsv_strobe, mem_valid, sc_done, sc_fail, sc_done_id}, 0);
        check("reset_rsv_zero", {rsv_addr, rsv_id, rsv_lr, rsv_sc, rsv_store}, 0);
        check("reset_mem_zero", {mem_addr, mem_id, mem_lr, mem_sc, mem_store}, 0);
        req_valid = '0;
        mon_en = 1'b1;

        for (int iter = 0; iter < 4000 && !done_flag; iter++) begin
            @(posedge clk);
            #1;
            cyc++;
            rst = 1'b0;

            if (phase == 3 && cyc == rst_cyc) begin
                rst = 1'b1;
                pend = '0;
            end
            if (phase == 3 && cyc == rst_cyc + 1) begin
                ack_q.delete(); rsv_q.delete(); mem_q.delete(); sc_q.delete();
                rr = 0; free_cycle = cyc; zero_chk_cyc = cyc;
            end
            if (phase == 3 && cyc == rst_cyc + 2) begin
                for (int p = 0; p < N; p++) begin
                    pend[p] = 1'b1; p_addr[p] = 30'($urandom);
                    p_lr[p] = 0; p_sc[p] = 0; p_store[p] = bit'($urandom_range(0, 1));
                end
                phase = 4;
            end

            if (phase == 0) begin
                for (int p = 0; p < N; p++) begin
                    if (!pend[p] && (cyc <= 12 || $urandom_range(0, 2) == 0)) begin
                        pend[p]    = 1'b1;
                        p_addr[p]  = 30'($urandom);
                        p_lr[p]    = bit'($urandom_range(0, 1));
                        p_sc[p]    = (cyc > 12) && ($urandom_range(0, 2) == 0);
                        p_store[p] = bit'($urandom_range(0, 1));
                    end
                end
                if (cyc >= 600) phase = 1;
            end
            if (phase == 1 && cyc >= free_cycle && pend == '0) begin
                pend[1] = 1'b1; p_addr[1] = 30'h100; p_lr[1] = 1; p_sc[1] = 1; p_store[1] = 1;
                phase = 2;
            end

            for (int p = 0; p < N; p++) begin
                req_valid[p] = pend[p];
                req_addr[30*p +: 30] = p_addr[p];
                req_lr[p] = p_lr[p];
                req_sc[p] = p_sc[p];
                req_store[p] = p_store[p];
            end

            if (!rst && cyc >= free_cycle && pend != '0) begin
                g = -1;
                for (int k = 0; k < N; k++) begin
                    q = (rr + k) % N;
                    if (g < 0 && pend[q]) g = q;
                end
                abort_plan = (cyc > 12 && phase < 2) ? bit'($urandom_range(0, 1)) : 1'b0;
                wt = (cyc <= 12) ? 0 : $urandom_range(0, 3);
                if (phase == 2) begin
                    wt = 10; rst_cyc = cyc + 3; phase = 3;
                end
                rsv_abort = abort_plan;
                lr_e = p_lr[g] && !p_sc[g];
                ack_q.push_back('{cyc, g});
                rsv_q.push_back('{cyc + 1, p_addr[g], g, lr_e, p_sc[g], p_store[g]});
                if (p_sc[g] && abort_plan) begin
                    sc_q.push_back('{cyc + 2, g, 1'b1});
                    free_cycle = cyc + 2;
                end else begin
                    ready_cycle = cyc + 2 + wt;
                    mem_q.push_back('{cyc + 2, ready_cycle, p_addr[g], g, lr_e, p_sc[g], p_store[g]});
                    if (p_sc[g]) sc_q.push_back('{ready_cycle + 1, g, 1'b0});
                    free_cycle = ready_cycle + 1;
                end
                $display("txn cycle=%0d port=%0d addr=0x%0h lr=%0d sc=%0d store=%0d abort=%0d wait=%0d",
                         cyc, g, p_addr[g], lr_e, p_sc[g], p_store[g], abort_plan, wt);
                rr = (g + 1) % N;
                pend[g] = 1'b0;
            end

            mem_ready = (cyc >= ready_cycle);
            if (phase == 4 && cyc > rst_cyc + 20 && cyc >= free_cycle && pend == '0) done_flag = 1'b1;
        end

        if (!done_flag) begin
            total++; bad++;
            $display("FAIL timeout cycle=%0d got=phase%0d expected=phase4_drained", cyc, phase);
        end
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        check("leftover_ack", ack_q.size(), 0);
        check("leftover_strobe", rsv_q.size(), 0);
        check("leftover_mem", mem_q.size(), 0);
        check("leftover_sc", sc_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
